// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction prefetch queue.
// The FSM encoding and the entry layout used by ifetch_queue and ifq_fifo.
package ifq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } ifq_state_t;

  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] PC_STEP = 32'd4;

  // One queue entry is {pc, inst}.
  localparam int ENTRY_W = 2 * INST_W;

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO holding {pc, inst} entries; the head slot drives the output directly.
// flush empties the queue in one cycle and takes priority over push and pop.
module ifq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  // A push into a full queue is only accepted when the head leaves in the same cycle.
  assign do_push = push && ((count != FULL) || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch stage: sequential word fetches over req/ack into a small queue,
// head presented to the core with valid/ready, redirect flushes and restarts fetch.
//
// Handshakes: mem_req/mem_addr are held until the one-cycle mem_ack pulse; the core
// side transfers an entry on any cycle with inst_valid && inst_ready.
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  ifq_state_t          state;
  ifq_state_t          state_next;
  logic [INST_W-1:0]   fetch_pc;
  logic [INST_W-1:0]   fetch_pc_next;
  logic [INST_W-1:0]   addr_next;
  logic [INST_W-1:0]   target;
  logic [CW-1:0]       count;
  logic [CW-1:0]       count_next;
  logic [ENTRY_W-1:0]  head;
  logic                push;
  logic                pop;

  assign target     = redirect_addr & 32'hFFFF_FFFC;
  // A redirect kills both the returning word and the core's accept in that cycle.
  assign push       = (state == FETCH) && mem_ack && !redirect;
  assign pop        = inst_valid && inst_ready && !redirect;
  assign count_next = count + CW'(push) - CW'(pop);
  assign inst_valid = (count != '0);
  assign {inst_pc, inst_out} = head;

  ifq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata ({fetch_pc, mem_rdata}),
    .rdata (head),
    .count (count)
  );

  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    addr_next     = mem_addr;
    if (push) begin
      fetch_pc_next = fetch_pc + PC_STEP;
    end
    if (redirect) begin
      fetch_pc_next = target;
    end
    case (state)
      IDLE: begin
        if (redirect) begin
          state_next = FETCH;
          addr_next  = target;
        end else if (count < FULL) begin
          state_next = FETCH;
          addr_next  = fetch_pc;
        end
      end
      FETCH: begin
        if (redirect) begin
          // Without an ack the old request is still in flight and must be drained.
          if (mem_ack) begin
            state_next = FETCH;
            addr_next  = target;
          end else begin
            state_next = DISCARD;
          end
        end else if (mem_ack) begin
          addr_next  = fetch_pc + PC_STEP;
          state_next = (count_next < FULL) ? FETCH : IDLE;
        end
      end
      DISCARD: begin
        if (mem_ack) begin
          state_next = FETCH;
          addr_next  = redirect ? target : fetch_pc;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      mem_req  <= (state_next != IDLE);
      mem_addr <= addr_next;
    end
  end

  ack_in_idle_a : assert property (@(posedge clk) disable iff (rst)
    !((state == IDLE) && mem_ack));

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: a latency-programmable memory model feeds the queue and a
// scoreboard of expected {pc, inst} entries is checked on every core-side transfer.
module tb_ifetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_addr = 32'h0;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;

  always #5 clk = ~clk;

  ifetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .inst_valid    (inst_valid),
    .inst_out      (inst_out),
    .inst_pc       (inst_pc),
    .inst_ready    (inst_ready)
  );

  typedef struct {
    logic [31:0] trig;
    int          lat;
    logic        with_ack;
    logic        rdy_pre;
    logic [31:0] raddr;
    logic [31:0] exp_pc;
  } redir_vec_t;

  logic [63:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          lat = 1;
  int          wait_cnt = 1;
  int          acks_accepted = 0;
  int          pops = 0;
  logic [31:0] exp_fetch = RESET_PC;
  logic [31:0] last_pop_pc = 32'h0;
  logic        drop_next = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_ge(input string name, input int act, input int min);
    checks++;
    if (act < min) begin
      errors++;
      $display("FAIL %s: got %0d expected at least %0d", name, act, min);
    end
  endtask

  // Memory slave: after each edge, ack once the request has waited lat cycles.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) begin
      mem_ack  = 1'b0;
      wait_cnt = lat;
    end else if (mem_ack) begin
      mem_ack  = 1'b0;
      wait_cnt = lat - 1;
    end else if (mem_req) begin
      if (wait_cnt == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_word(mem_addr);
      end else begin
        wait_cnt--;
      end
    end else begin
      wait_cnt = lat;
    end
  endtask

  // Core-side driver plus scoreboard bookkeeping for the cycle just started.
  task automatic drive(input logic rdy, input logic redir, input logic [31:0] raddr);
    logic [63:0] head;
    inst_ready    = rdy;
    redirect      = redir;
    redirect_addr = raddr;
    if (rst) begin
      exp_q.delete();
      exp_fetch = RESET_PC;
      drop_next = 1'b0;
      return;
    end
    if (inst_valid && rdy && !redir) begin
      pops++;
      last_pop_pc = inst_pc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got pc %h expected no entry", inst_pc);
      end else begin
        head = exp_q.pop_front();
        check("pop_pc", inst_pc, head[63:32]);
        check("pop_inst", inst_out, head[31:0]);
      end
    end
    if (redir) begin
      exp_q.delete();
      exp_fetch = raddr & 32'hFFFF_FFFC;
      if (mem_ack) drop_next = 1'b0;
      else if (mem_req) drop_next = 1'b1;
    end else if (mem_ack) begin
      if (drop_next) begin
        drop_next = 1'b0;
      end else begin
        check("fetch_addr", mem_addr, exp_fetch);
        exp_q.push_back({exp_fetch, mem_word(exp_fetch)});
        exp_fetch = exp_fetch + 32'd4;
        acks_accepted++;
      end
    end
  endtask

  task automatic cyc(input logic rdy);
    tick();
    drive(rdy, 1'b0, 32'h0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      drive(1'b0, 1'b0, 32'h0);
    end
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    redir_vec_t vecs[4];
    redir_vec_t v;
    int         p0;
    int         n;
    logic       found;

    vecs[0] = '{32'h0000_0008, 3, 1'b0, 1'b1, 32'h0000_0100, 32'h0000_0100};
    vecs[1] = '{32'h0000_0004, 1, 1'b1, 1'b0, 32'h0000_0203, 32'h0000_0200};
    vecs[2] = '{32'h0000_0010, 1, 1'b0, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFF8};
    vecs[3] = '{32'h0000_000C, 2, 1'b1, 1'b1, 32'h0000_1001, 32'h0000_1000};

    // Reset values and first-fetch latency.
    lat = 1;
    do_reset(3);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, RESET_PC);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst_out", inst_out, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    tick();
    check("c1_mem_req", 32'(mem_req), 32'd1);
    check("c1_mem_addr", mem_addr, RESET_PC);
    drive(1'b1, 1'b0, 32'h0);
    tick();
    check("c2_inst_valid", 32'(inst_valid), 32'd0);
    drive(1'b1, 1'b0, 32'h0);
    tick();
    check("c3_inst_valid", 32'(inst_valid), 32'd1);
    drive(1'b1, 1'b0, 32'h0);
    p0 = pops;
    for (int i = 0; i < 30; i++) cyc(1'b1);
    check_ge("stream_pops", pops - p0, 10);

    // Back-pressure: queue fills to DEPTH, fetch stops, resumes at 0x10.
    tick();
    drive(1'b0, 1'b1, 32'h0);
    acks_accepted = 0;
    for (int i = 0; i < 16; i++) cyc(1'b0);
    check("full_acks", acks_accepted, DEPTH);
    check("full_mem_req", 32'(mem_req), 32'd0);
    check("full_inst_valid", 32'(inst_valid), 32'd1);
    check("full_head_pc", inst_pc, 32'h0);
    check("full_head_inst", inst_out, mem_word(32'h0));
    n = 0;
    do begin
      cyc(1'b1);
      n++;
    end while (!mem_req && n < 8);
    check("resume_mem_req", 32'(mem_req), 32'd1);
    check("resume_mem_addr", mem_addr, 32'h0000_0010);
    for (int i = 0; i < 20; i++) cyc(1'b1);

    // Redirect vectors: in-flight request, same-cycle ack, wrap, unaligned target.
    for (int k = 0; k < 4; k++) begin
      v   = vecs[k];
      lat = v.lat;
      do_reset(2);
      found = 1'b0;
      for (int c = 0; c < 60 && !found; c++) begin
        tick();
        if (mem_req && mem_addr == v.trig && mem_ack == v.with_ack) begin
          found = 1'b1;
          drive(1'b1, 1'b1, v.raddr);
        end else begin
          drive(v.rdy_pre, 1'b0, 32'h0);
        end
      end
      check("redir_trigger_seen", 32'(found), 32'd1);
      tick();
      check("redir_mem_req", 32'(mem_req), 32'd1);
      check("redir_mem_addr", mem_addr, v.with_ack ? v.exp_pc : v.trig);
      check("redir_flushed", 32'(inst_valid), 32'd0);
      drive(1'b1, 1'b0, 32'h0);
      p0 = pops;
      n  = 0;
      while (pops == p0 && n < 40) begin
        cyc(1'b1);
        n++;
      end
      check_ge("redir_first_pop", pops - p0, 1);
      check("redir_first_pc", last_pop_pc, v.exp_pc);
      for (int i = 0; i < 16; i++) cyc(1'b1);
      check_ge("redir_pops", pops - p0, 3);
    end

    // Reset while fetching with two entries queued.
    lat = 1;
    do_reset(2);
    acks_accepted = 0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      cyc(1'b0);
      if (acks_accepted == 2 && !mem_ack && mem_req) found = 1'b1;
    end
    check("midrst_setup_seen", 32'(found), 32'd1);
    check("midrst_pre_valid", 32'(inst_valid), 32'd1);
    rst = 1'b1;
    tick();
    drive(1'b0, 1'b0, 32'h0);
    check("midrst_inst_valid", 32'(inst_valid), 32'd0);
    check("midrst_mem_req", 32'(mem_req), 32'd0);
    check("midrst_mem_addr", mem_addr, RESET_PC);
    rst = 1'b0;
    p0 = pops;
    n  = 0;
    while (pops == p0 && n < 20) begin
      cyc(1'b1);
      n++;
    end
    check_ge("midrst_restart_pop", pops - p0, 1);
    check("midrst_restart_pc", last_pop_pc, RESET_PC);
    for (int i = 0; i < 10; i++) cyc(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction prefetch stage between a multi-cycle instruction memory and the MIPS core's instruction input.
- Issues sequential word fetches over a req/ack handshake and buffers the returned words with their PCs in a small FIFO.
- Presents the head entry to the core with a valid/ready handshake.
- A core redirect (taken branch, J, JAL, JR) flushes the queue and restarts fetch at the new address.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_req  output  1  fetch request; held until mem_ack.
- mem_addr  output  32  fetch word address; stable while mem_req is high.
- mem_ack  input  1  one-cycle pulse; mem_rdata is valid this cycle.
- mem_rdata  input  32  fetched instruction word.
- redirect  input  1  flush and restart fetch at redirect_addr.
- redirect_addr  input  32  new PC; bits [1:0] are ignored and forced to 0.
- inst_valid  output  1  head entry is valid.
- inst_out  output  32  head instruction word.
- inst_pc  output  32  PC of the head instruction.
- inst_ready  input  1  core accepts the head entry this cycle.

Behaviour:
- Reset (synchronous, active-high): overrides all other inputs.
  - mem_req=0, mem_addr=RESET_PC, inst_valid=0, inst_out=0, inst_pc=0.
  - fetch_pc=RESET_PC, count=0, read/write pointers=0, state=IDLE.
  - Any outstanding request is abandoned; the memory slave shares rst.
- All outputs are registered.
  - inst_out/inst_pc come straight from the head FIFO slot.
  - inst_valid = (count != 0).
- FSM states: IDLE, FETCH, DISCARD.
- IDLE:
  - If count < DEPTH: next cycle mem_req=1, mem_addr=fetch_pc, go to FETCH.
  - Otherwise stay in IDLE.
- FETCH: mem_req high, mem_addr stable until mem_ack.
  - On mem_ack: write {fetch_pc, mem_rdata} to the tail, then fetch_pc += 4 (32-bit wrap, FFFF_FFFC -> 0000_0000).
  - If count_next < DEPTH: stay in FETCH with the new mem_addr; back-to-back requests are allowed and mem_req does not drop.
  - Otherwise: mem_req=0, go to IDLE.
- DISCARD: mem_req stays high on the old address until mem_ack.
  - The returned data is dropped.
  - Then fetch restarts at fetch_pc (already the redirect target): next state is FETCH with mem_req=1.
- Latency:
  - mem_ack in cycle t: the entry is visible (inst_valid) in cycle t+1.
  - After rst falls: mem_req=1 in the 1st cycle, the minimum first inst_valid is cycle 3 given a single-cycle ack.
- Pop: inst_valid && inst_ready advances the head. count_next = count + push - pop.
  - Simultaneous push and pop when full is legal; count is unchanged.
- Redirect (priority over pop and push):
  - count<=0, pointers<=0, fetch_pc<=redirect_addr; a pop in the same cycle is ignored.
  - State IDLE: go to FETCH with mem_addr=redirect_addr.
  - State FETCH without mem_ack this cycle: go to DISCARD.
  - State FETCH with mem_ack this cycle: the data is discarded; go to FETCH at redirect_addr (no DISCARD).
  - State DISCARD: update fetch_pc; remain in DISCARD unless mem_ack is present, then go to FETCH.
- Boundaries:
  - inst_ready with inst_valid=0 has no effect.
  - mem_ack in IDLE is ignored (protocol violation; flag via assertion).
  - Empty plus ack plus ready in the same cycle: there is no bypass; the entry appears next cycle.

Decomposition:
- Shared package `ifq_pkg`:
  - State encoding localparams: IDLE=2'd0, FETCH=2'd1, DISCARD=2'd2.
  - Width constant INST_W=32.
  - Constant PC_STEP=32'd4.
- One sub-module, `ifq_fifo`:
  - Parameterised DEPTH by WIDTH=64 synchronous FIFO.
  - Ports: push, pop, flush, count.
  - Holds {pc, inst}.
- The FSM and fetch_pc live in `ifetch_queue`.

Test Plan:
- Reset, then 1-cycle ack memory returning mem[a] = a ^ 32'hA5A5_0000 -> core sees PCs 0,4,8,... with matching data; mem_req first high in the cycle after rst falls.
- inst_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 acks accepted, mem_req=0, count=4; set inst_ready=1 -> fetch resumes at PC 0x10.
- Redirect to 0x0000_0100 while a request for 0x8 is outstanding, ack 3 cycles later -> the 0x8 data is never presented; next mem_addr=0x100; first inst_pc=0x100.
- Redirect in the same cycle as mem_ack and inst_ready, with redirect_addr=0x203 -> ack data dropped, pop ignored, mem_addr=0x200 next cycle.
- fetch_pc=0xFFFF_FFF8 via redirect -> PCs FFFF_FFF8, FFFF_FFFC, 0000_0000 are presented in order.
- rst asserted mid-FETCH with count=2 -> next cycle inst_valid=0, mem_req=0, mem_addr=RESET_PC; normal restart follows.
